delayed_anyedge_checker: RTL and testbench

Synthesizable responder for the delayed any-edge handshake. A producer drives flag_b low, later toggles flag_a, then raises flag_b. This block watches both signals in clk cycles. On any edge of flag_a it checks that flag_b is 0 at the edge. It checks that flag_b is 1 exactly CHECK_DELAY cycles later. After FINISH_DELAY further cycles it reports pass or fail. It sits beside the flag producer as an on-chip protocol monitor.

---
 rtl/delayed_anyedge_checker_pkg.sv | 17 +
 rtl/delayed_anyedge_checker_anyedge_detect.sv | 25 ++
 rtl/delayed_anyedge_checker.sv | 148 ++++++++++++++
 tb/tb_delayed_anyedge_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/delayed_anyedge_checker_pkg.sv
// Shared types and constants for the delayed any-edge handshake checker.
package delayed_anyedge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic EXP_FIRST  = 1'b0;
    localparam logic EXP_SECOND = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/delayed_anyedge_checker_anyedge_detect.sv
// Any-edge detector on a clk-synchronous input; the first cycle after reset
// only captures the level, so a high input at reset release is not an edge.
module anyedge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic edge_o
);

    logic a_q;
    logic arm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= 1'b0;
            arm_q <= 1'b0;
        end else begin
            a_q   <= d;
            arm_q <= 1'b1;
        end
    end

    assign edge_o = arm_q & (d ^ a_q);

endmodule

// File: rtl/delayed_anyedge_checker.sv
// Protocol monitor: on each accepted flag_a edge, flag_b must be low at the
// edge and high CHECK_DELAY cycles later; result reported FINISH_DELAY after.
module delayed_anyedge_checker
    import delayed_anyedge_pkg::*;
#(
    parameter int CHECK_DELAY  = 25,
    parameter int FINISH_DELAY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_a,
    input  logic             flag_b,
    input  logic             clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_first,
    output logic             err_second,
    output logic             err_sticky,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] missed_cnt
);

    localparam int             DW      = $clog2(max2(CHECK_DELAY, FINISH_DELAY) + 1);
    localparam logic [DW-1:0]  CD_LOAD = DW'(CHECK_DELAY - 1);
    localparam logic [DW-1:0]  FD_LOAD = DW'((FINISH_DELAY > 0) ? FINISH_DELAY - 1 : 0);

    logic edge_w;

    anyedge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (flag_a),
        .edge_o (edge_w)
    );

    state_e           state_q, state_d;
    logic [DW-1:0]    cnt_q, cnt_d;
    logic             chk_err_q, chk_err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             errf_q, errf_d;
    logic             errs_q, errs_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             inc_e, inc_m;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chk_err_d = chk_err_q;
        done_d    = 1'b0;
        pass_d    = 1'b0;
        errf_d    = 1'b0;
        errs_d    = 1'b0;
        inc_e     = 1'b0;
        inc_m     = 1'b0;

        case (state_q)
            IDLE: begin
                if (edge_w) begin
                    state_d   = WAIT;
                    cnt_d     = CD_LOAD;
                    errf_d    = (flag_b != EXP_FIRST);
                    chk_err_d = errf_d;
                    inc_e     = 1'b1;
                end
            end
            WAIT: begin
                inc_m = edge_w;
                if (cnt_q == '0) begin
                    errs_d    = (flag_b != EXP_SECOND);
                    chk_err_d = chk_err_q | errs_d;
                    if (FINISH_DELAY == 0) begin
                        done_d  = 1'b1;
                        pass_d  = ~chk_err_d;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = FD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                inc_m = edge_w;
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    pass_d  = ~chk_err_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error outranks a simultaneous clear of the sticky flag.
        sticky_d = (sticky_q & ~clear) | errf_d | errs_d;

        if (clear)                       ecnt_d = '0;
        else if (inc_e && ecnt_q != '1)  ecnt_d = ecnt_q + 1'b1;
        else                             ecnt_d = ecnt_q;

        if (clear)                       mcnt_d = '0;
        else if (inc_m && mcnt_q != '1)  mcnt_d = mcnt_q + 1'b1;
        else                             mcnt_d = mcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            chk_err_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            errf_q    <= 1'b0;
            errs_q    <= 1'b0;
            sticky_q  <= 1'b0;
            ecnt_q    <= '0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chk_err_q <= chk_err_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            errf_q    <= errf_d;
            errs_q    <= errs_d;
            sticky_q  <= sticky_d;
            ecnt_q    <= ecnt_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_first  = errf_q;
    assign err_second = errs_q;
    assign err_sticky = sticky_q;
    assign edge_cnt   = ecnt_q;
    assign missed_cnt = mcnt_q;

endmodule

// File: tb/tb_delayed_anyedge_checker.sv
// Bench for delayed_anyedge_checker: two configurations against a cycle-indexed
// reference model, plus hand-computed expectations for the nominal scenarios.
module tb_delayed_anyedge_checker;

    logic clk = 1'b0, rst_n = 1'b0, flag_a = 1'b0, flag_b = 1'b0, clear = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: nominal delays, narrow counters; u1: short check, zero finish delay.
    logic       busy0, done0, pass0, ef0, es0, st0;
    logic [3:0] ec0, mc0;
    logic       busy1, done1, pass1, ef1, es1, st1;
    logic [2:0] ec1, mc1;

    delayed_anyedge_checker #(.CHECK_DELAY(25), .FINISH_DELAY(1), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n), .flag_a(flag_a), .flag_b(flag_b), .clear(clear),
        .busy(busy0), .done(done0), .pass(pass0), .err_first(ef0), .err_second(es0),
        .err_sticky(st0), .edge_cnt(ec0), .missed_cnt(mc0));

    delayed_anyedge_checker #(.CHECK_DELAY(3), .FINISH_DELAY(0), .CNT_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .flag_a(flag_a), .flag_b(flag_b), .clear(clear),
        .busy(busy1), .done(done1), .pass(pass1), .err_first(ef1), .err_second(es1),
        .err_sticky(st1), .edge_cnt(ec1), .missed_cnt(mc1));

    function automatic int cdv(input int i); return (i == 0) ? 25 : 3; endfunction
    function automatic int fdv(input int i); return (i == 0) ? 1 : 0;  endfunction
    function automatic int cmax(input int i); return (i == 0) ? 15 : 7; endfunction

    // Reference model: a check is described by its start cycle; the second
    // sample and the report fall at fixed cycle offsets from it.
    bit  m_arm[2], m_pa[2], m_in[2], m_cerr[2];
    bit  m_done[2], m_pass[2], m_ef[2], m_es[2], m_st[2];
    int  m_t0[2], m_ec[2], m_mc[2];
    int  cyc = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_arm[i] = 0; m_pa[i] = 0; m_in[i] = 0; m_cerr[i] = 0;
                m_done[i] = 0; m_pass[i] = 0; m_ef[i] = 0; m_es[i] = 0; m_st[i] = 0;
                m_ec[i] = 0; m_mc[i] = 0; m_t0[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                bit e, ie, im;
                e = m_arm[i] && (flag_a != m_pa[i]);
                m_pa[i] = flag_a; m_arm[i] = 1;
                m_done[i] = 0; m_pass[i] = 0; m_ef[i] = 0; m_es[i] = 0;
                ie = 0; im = 0;
                if (!m_in[i]) begin
                    if (e) begin
                        m_in[i] = 1; m_t0[i] = cyc; ie = 1;
                        m_ef[i] = flag_b; m_cerr[i] = flag_b;
                    end
                end else begin
                    im = e;
                    if (cyc == m_t0[i] + cdv(i)) begin
                        m_es[i] = !flag_b;
                        m_cerr[i] = m_cerr[i] || m_es[i];
                    end
                    if (cyc == m_t0[i] + cdv(i) + fdv(i)) begin
                        m_done[i] = 1; m_pass[i] = !m_cerr[i]; m_in[i] = 0;
                    end
                end
                m_st[i] = (m_st[i] && !clear) || m_ef[i] || m_es[i];
                if (clear) m_ec[i] = 0; else if (ie && m_ec[i] < cmax(i)) m_ec[i]++;
                if (clear) m_mc[i] = 0; else if (im && m_mc[i] < cmax(i)) m_mc[i]++;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int i, input logic b, input logic d, input logic p,
                            input logic f, input logic s, input logic st,
                            input logic [15:0] ec, input logic [15:0] mc);
        chk($sformatf("u%0d busy", i),       {15'd0, b},  {15'd0, m_in[i]});
        chk($sformatf("u%0d done", i),       {15'd0, d},  {15'd0, m_done[i]});
        chk($sformatf("u%0d pass", i),       {15'd0, p},  {15'd0, m_pass[i]});
        chk($sformatf("u%0d err_first", i),  {15'd0, f},  {15'd0, m_ef[i]});
        chk($sformatf("u%0d err_second", i), {15'd0, s},  {15'd0, m_es[i]});
        chk($sformatf("u%0d err_sticky", i), {15'd0, st}, {15'd0, m_st[i]});
        chk($sformatf("u%0d edge_cnt", i),   ec, 16'(m_ec[i]));
        chk($sformatf("u%0d missed_cnt", i), mc, 16'(m_mc[i]));
    endtask

    task automatic compare_all();
        cmp_inst(0, busy0, done0, pass0, ef0, es0, st0, 16'(ec0), 16'(mc0));
        cmp_inst(1, busy1, done1, pass1, ef1, es1, st1, 16'(ec1), 16'(mc1));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic tickn(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // reset state
        tickn(2);
        chk("reset busy", {15'd0, busy0}, 16'd0);
        chk("reset done", {15'd0, done0}, 16'd0);
        chk("reset edge_cnt", 16'(ec0), 16'd0);
        chk("reset sticky", {15'd0, st0}, 16'd0);
        rst_n = 1'b1;
        tickn(3);

        // nominal pass
        flag_a = 1'b1; tick();
        chk("nom busy", {15'd0, busy0}, 16'd1);
        chk("nom err_first", {15'd0, ef0}, 16'd0);
        chk("nom edge_cnt", 16'(ec0), 16'd1);
        tickn(14);
        flag_b = 1'b1; tickn(11);
        chk("nom err_second", {15'd0, es0}, 16'd0);
        chk("nom done early", {15'd0, done0}, 16'd0);
        tick();
        chk("nom done", {15'd0, done0}, 16'd1);
        chk("nom pass", {15'd0, pass0}, 16'd1);
        chk("nom model pass", {15'd0, m_pass[0]}, 16'd1);
        chk("nom sticky", {15'd0, st0}, 16'd0);
        tick();
        chk("nom idle", {15'd0, busy0}, 16'd0);

        // flag_b already high at the edge
        flag_a = 1'b0; tick();
        chk("early err_first", {15'd0, ef0}, 16'd1);
        chk("early model err_first", {15'd0, m_ef[0]}, 16'd1);
        tickn(25);
        chk("early err_second", {15'd0, es0}, 16'd0);
        tick();
        chk("early done", {15'd0, done0}, 16'd1);
        chk("early pass", {15'd0, pass0}, 16'd0);
        chk("early sticky", {15'd0, st0}, 16'd1);
        tick();

        // flag_b raised too late
        flag_b = 1'b0; flag_a = 1'b1; tick();
        tickn(25);
        chk("late err_second", {15'd0, es0}, 16'd1);
        tick();
        chk("late done", {15'd0, done0}, 16'd1);
        chk("late pass", {15'd0, pass0}, 16'd0);
        tickn(3);
        flag_b = 1'b1; tick();

        // clear
        chk("pre-clear edge_cnt", 16'(ec0), 16'd3);
        chk("pre-clear sticky", {15'd0, st0}, 16'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear sticky", {15'd0, st0}, 16'd0);
        chk("clear edge_cnt", 16'(ec0), 16'd0);
        chk("clear missed_cnt", 16'(mc0), 16'd0);

        // falling edge with re-triggers
        flag_b = 1'b0; flag_a = 1'b0; tick();
        tickn(4);
        flag_a = 1'b1; tick();
        chk("retrig missed 1", 16'(mc0), 16'd1);
        flag_b = 1'b1; tickn(20);
        flag_a = 1'b0; tick();
        chk("retrig done", {15'd0, done0}, 16'd1);
        chk("retrig pass", {15'd0, pass0}, 16'd1);
        chk("retrig missed 2", 16'(mc0), 16'd2);
        chk("retrig edge_cnt 1", 16'(ec0), 16'd1);
        flag_b = 1'b0; flag_a = 1'b1; tick();
        chk("retrig accepted", {15'd0, busy0}, 16'd1);
        chk("retrig edge_cnt 2", 16'(ec0), 16'd2);
        chk("retrig single done", {15'd0, done0}, 16'd0);
        tickn(30);

        // reset release with flag_a high, then reset mid-check
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tickn(3);
        chk("rel no edge busy", {15'd0, busy0}, 16'd0);
        chk("rel no edge cnt", 16'(ec0), 16'd0);
        flag_a = 1'b0; tick();
        chk("rel edge busy", {15'd0, busy0}, 16'd1);
        tickn(9);
        rst_n = 1'b0; #1;
        compare_all();
        chk("midrst busy", {15'd0, busy0}, 16'd0);
        chk("midrst edge_cnt", 16'(ec0), 16'd0);
        tickn(2);
        rst_n = 1'b1; tickn(30);

        // randomized traffic
        for (int n = 0; n < 5000; n++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 5) == 0) flag_a = ~flag_a;
            if ($urandom_range(0, 9) == 0) flag_b = ~flag_b;
            clear = ($urandom_range(0, 399) == 0);
            tick();
        end
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
